uart_rx_oversample: RTL
=======================

// Module: uart_rx_oversample
// PURPOSE
//  UART receiver; consumes baud_tick_16x from uart_baud_generator (BAUD_RATE x16 enable pulses).
//  Synchronises serial rx, finds the start bit, majority-samples each bit at mid-period.
//  Delivers bytes through a one-entry valid/ready holding register; flags framing, parity and overrun.
// PARAMETERS
//  DATA_BITS   8   payload bits per frame (5..8), LSB first
//  PARITY_EN   0   1 = parity bit after data
//  PARITY_ODD  0   1 = odd parity, 0 = even (ignored when PARITY_EN=0)
// PORTS
//  clk            in   1          system clock
//  rst            in   1          reset; asynchronous assert, active-low (0 = reset)
//  baud_tick_16x  in   1          1-clk enable pulse, 16 per bit period
//  rx             in   1          asynchronous serial input, idle high
//  rx_data        out  DATA_BITS  received byte, stable while rx_valid=1
//  rx_valid       out  1          holding register full
//  rx_ready       in   1          consumer accepts; pop when rx_valid & rx_ready
//  frame_err      out  1          1-clk pulse: stop bit sampled 0
//  parity_err     out  1          1-clk pulse: parity mismatch
//  overrun        out  1          sticky; frame completed while holding register full
//  busy           out  1          FSM not in IDLE
// BEHAVIOUR
//  - Reset: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0; sync FFs=1; FSM=IDLE.
//  - Reset mid-frame aborts: partial byte discarded, holding register cleared, overrun cleared.
//  - rx passes a 2-FF synchroniser (reset value 1); all logic uses rx_s. 2-clk input latency.
//  - tick_cnt (4b) and bit_cnt (3b) advance only on baud_tick_16x; no activity between ticks.
//  - Sample = majority of rx_s at tick_cnt 7, 8, 9; decision taken at tick 9.
//  - FSM: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
//    IDLE: on tick with rx_s=0 -> START, tick_cnt=0.
//    START: at tick 9, sample=1 -> IDLE (glitch rejected); sample=0 -> continue; at tick 15 -> DATA.
//    DATA: shift sample in at MSB of shift reg (LSB-first line); after DATA_BITS bits -> PARITY or STOP.
//    PARITY: compare sample with XOR(data)^PARITY_ODD; mismatch latched for end of frame.
//    STOP: decision at tick 9 (frame ends mid-stop-bit, no wait to tick 15):
//      sample=1 & no parity err -> deliver; -> IDLE.
//      sample=1 & parity err -> parity_err pulse, byte dropped; -> IDLE.
//      sample=0 -> frame_err pulse, byte dropped (parity_err suppressed); -> WAIT_IDLE.
//    WAIT_IDLE: stay until a tick sees rx_s=1 (break/line-low tolerance), then IDLE.
//  - Deliver: if rx_valid=0 or (rx_valid & rx_ready) same clk -> load rx_data, rx_valid=1.
//    If rx_valid=1 & rx_ready=0 -> overrun=1, old rx_data kept, new byte dropped.
//  - Pop: rx_valid & rx_ready -> rx_valid=0 next clk unless a delivery lands the same clk (stays 1, new data).
//  - overrun clears only on reset. frame_err/parity_err high exactly one clk.
//  - Latency: rx_valid rises 1 clk after the baud_tick_16x at tick 9 of the stop bit.
//  - DATA_BITS<8: rx_data sized DATA_BITS; shift reg right-justified so bit0 = first data bit.
// STRUCTURE
//  - Shared uart_defs include: FSM state localparams, OVERSAMPLE=16, SAMPLE_MID=8 (majority window 7..9).
//  - Sub-module uart_rx_sync: 2-FF synchroniser, reset-to-1, reused by future blocks.
//  - Remainder (FSM, counters, majority, shift reg, holding reg) inline here.
// TESTING  (uart_baud_generator CLOCK_FREQ=1000000, BAUD_RATE=10000; bit = 16 ticks)
//  - Frame 0xA5, 8N1, rx_ready=1 -> one rx_valid pulse, rx_data=0xA5, no error flags.
//  - rx low for 4 ticks then high -> FSM back to IDLE, no rx_valid, no errors.
//  - 0x3C with stop bit 0, line held low 3 bits -> frame_err 1 clk, no rx_valid, busy until rx high.
//  - PARITY_EN=1 even, 0x07 with parity bit 0 -> parity_err 1 clk, no rx_valid; with bit 1 -> valid 0x07.
//  - 0x11 then 0x22, rx_ready=0 -> rx_data=0x11, overrun=1; rx_ready=1 -> rx_valid=0 next clk.
//  - rst=0 during data bit 4 of 0xFF, release -> all outputs 0; next frame 0x5A received cleanly.
//  - Single-sample glitch (1 tick) mid data bit of 0x00 -> majority keeps 0, rx_data=0x00.

Source files
------------

// File: rtl/uart_rx_oversample_pkg.sv
// Shared UART receiver definitions: FSM states, oversampling constants and the
// majority-vote helper used by the bit sampler.
package uart_rx_oversample_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;

  // Majority window is SAMPLE_MID-1 .. SAMPLE_MID+1; the decision lands on the last one.
  localparam logic [3:0] TICK_MAJ_A  = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] TICK_MAJ_B  = 4'(SAMPLE_MID);
  localparam logic [3:0] TICK_DECIDE = 4'(SAMPLE_MID + 1);
  localparam logic [3:0] TICK_LAST   = 4'(OVERSAMPLE - 1);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_oversample_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high serial input.
module uart_rx_oversample_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Reset to 1 so a released reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver with majority-voted bit sampling, a one-entry
// valid/ready holding register, and framing/parity/overrun reporting.
module uart_rx_oversample
  import uart_rx_oversample_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  rx_state_e              r_state;
  rx_state_e              w_state_nxt;
  logic                   w_rx_s;
  logic [3:0]             r_tick_cnt;
  logic [2:0]             r_bit_cnt;
  logic                   r_smp_a;
  logic                   r_smp_b;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_err;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_perr;
  logic                   r_overrun;
  logic                   w_sample;
  logic                   w_decide;
  logic                   w_last;
  logic                   w_last_bit;
  logic                   w_exp_par;
  logic                   w_deliver;
  logic                   w_ferr;
  logic                   w_perr;

  uart_rx_oversample_sync u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  assign w_sample   = majority3(r_smp_a, r_smp_b, w_rx_s);
  assign w_decide   = baud_tick_16x && (r_tick_cnt == TICK_DECIDE);
  assign w_last     = baud_tick_16x && (r_tick_cnt == TICK_LAST);
  assign w_last_bit = (r_bit_cnt == 3'(DATA_BITS - 1));
  assign w_exp_par  = (^r_shift) ^ PARITY_ODD;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and end-of-frame strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    w_perr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (baud_tick_16x && !w_rx_s) w_state_nxt = ST_START;
        else                          w_state_nxt = ST_IDLE;
      end
      ST_START: begin
        if (w_decide && w_sample) w_state_nxt = ST_IDLE;
        else if (w_last)          w_state_nxt = ST_DATA;
        else                      w_state_nxt = ST_START;
      end
      ST_DATA: begin
        if (w_last && w_last_bit) w_state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
        else                      w_state_nxt = ST_DATA;
      end
      ST_PARITY: begin
        if (w_last) w_state_nxt = ST_STOP;
        else        w_state_nxt = ST_PARITY;
      end
      ST_STOP: begin
        // Frame ends mid-stop-bit so a back-to-back start edge is never missed.
        if (w_decide) begin
          w_state_nxt = w_sample ? ST_IDLE : ST_WAIT_IDLE;
          w_deliver   = w_sample && !r_par_err;
          w_perr      = w_sample && r_par_err;
          w_ferr      = !w_sample;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_WAIT_IDLE: begin
        if (baud_tick_16x && w_rx_s) w_state_nxt = ST_IDLE;
        else                         w_state_nxt = ST_WAIT_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Tick/bit counters, majority samples, shift register and parity check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_smp_a    <= 1'b1;
      r_smp_b    <= 1'b1;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
    end else if (baud_tick_16x) begin
      if (r_state == ST_IDLE) r_tick_cnt <= 4'd0;
      else                    r_tick_cnt <= r_tick_cnt + 4'd1;
      if (r_tick_cnt == TICK_MAJ_A) r_smp_a <= w_rx_s;
      if (r_tick_cnt == TICK_MAJ_B) r_smp_b <= w_rx_s;
      case (r_state)
        ST_START: begin
          r_bit_cnt <= 3'd0;
          r_par_err <= 1'b0;
        end
        ST_DATA: begin
          if (r_tick_cnt == TICK_DECIDE) r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
          if (r_tick_cnt == TICK_LAST && !w_last_bit) r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        ST_PARITY: begin
          if (r_tick_cnt == TICK_DECIDE) r_par_err <= (w_sample != w_exp_par);
        end
        default: begin
          r_bit_cnt <= r_bit_cnt;
        end
      endcase
    end
  end

  // Holding register, overrun flag and single-cycle error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      r_perr <= w_perr;
      if (w_deliver) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign overrun    = r_overrun;
  assign busy       = (r_state != ST_IDLE);

endmodule
